// File: rtl/bridge_n_pkg.sv
// Shared constants for bridge_n: control-slot register map and default decode tag.
package bridge_n_pkg;

  typedef enum logic [1:0] {
    REG_MASK = 2'd0,
    REG_PEND = 2'd1,
    REG_CLR  = 2'd2,
    REG_MODE = 2'd3
  } ctrl_reg_e;

  localparam logic [27:0] DEFAULT_BASE_TAG = 28'h00007f0;
  localparam int          HWINT_W          = 6;

endpackage

// File: rtl/bridge_n_if.sv
// CPU-side data-memory bus of the bridge: word address, byte enables, write data/strobe, read data.
interface bridge_n_if;
  logic [31:2] PrAddr;
  logic [3:0]  PrBE;
  logic [31:0] PrWD;
  logic        PrWe;
  logic [31:0] PrRD;

  modport master (output PrAddr, PrBE, PrWD, PrWe, input  PrRD);
  modport slave  (input  PrAddr, PrBE, PrWD, PrWe, output PrRD);
endinterface

// File: rtl/bridge_n_irq_ctrl.sv
// Interrupt controller: MASK/MODE/PEND/prev registers and registered HWInt generation.
module bridge_n_irq_ctrl
  import bridge_n_pkg::*;
#(
  parameter int N_DEV = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  ctrl_reg_e          wr_idx,
  input  logic [N_DEV-1:0]   wr_data,
  input  logic [N_DEV-1:0]   dev_int,
  output logic [N_DEV-1:0]   mask,
  output logic [N_DEV-1:0]   mode,
  output logic [N_DEV-1:0]   pend,
  output logic [HWINT_W-1:0] hw_int
);

  logic [N_DEV-1:0]   mask_q, mask_d;
  logic [N_DEV-1:0]   mode_q, mode_d;
  logic [N_DEV-1:0]   pend_q, pend_d;
  logic [N_DEV-1:0]   prev_q, prev_d;
  logic [HWINT_W-1:0] hw_int_q, hw_int_d;
  logic [N_DEV-1:0]   clr;

  always_comb begin
    // NOTE: every signal gets a default before the branches so no latch is inferred.
    mask_d   = mask_q;
    mode_d   = mode_q;
    clr      = '0;
    hw_int_d = '0;
    if (wr_en) begin
      case (wr_idx)
        REG_MASK: mask_d = wr_data;
        REG_CLR:  clr    = wr_data;
        REG_MODE: mode_d = wr_data;
        default:  ;
      endcase
    end
    prev_d = dev_int;
    // Edge sources: sticky, new edge beats a same-cycle clear. Level sources follow the input.
    pend_d = (mode_q & ((pend_q & ~clr) | (dev_int & ~prev_q)))
           | (~mode_q & dev_int);
    hw_int_d[N_DEV-1:0] = pend_q & mask_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q   <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      prev_q   <= '0;
      hw_int_q <= '0;
    end else begin
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      prev_q   <= prev_d;
      hw_int_q <= hw_int_d;
    end
  end

  assign mask   = mask_q;
  assign mode   = mode_q;
  assign pend   = pend_q;
  assign hw_int = hw_int_q;

endmodule

// File: rtl/bridge_n.sv
// System bridge: decodes the CPU word address onto N_DEV peripheral slots plus an interrupt control slot.
module bridge_n
  import bridge_n_pkg::*;
#(
  parameter int          N_DEV    = 2,
  parameter logic [27:0] BASE_TAG = DEFAULT_BASE_TAG
) (
  input  logic                 clk,
  input  logic                 reset,
  bridge_n_if.slave            bus,
  output logic [7:2]           HWInt,
  output logic                 bri,
  output logic [3:2]           ADDR,
  output logic [31:0]          wdata,
  output logic [3:0]           BE,
  output logic [N_DEV-1:0]     dev_we,
  input  logic [32*N_DEV-1:0]  dev_rdata,
  input  logic [N_DEV-1:0]     dev_int
);

  localparam logic [27:0] CTRL_TAG = BASE_TAG + 28'(N_DEV);

  logic [27:0]        tag;
  logic [N_DEV-1:0]   hit;
  logic               ctrl_hit;
  logic               ctrl_we;
  ctrl_reg_e          reg_idx;
  logic [N_DEV-1:0]   mask, mode, pend;
  logic [HWINT_W-1:0] hw_int;
  logic [31:0]        rdata;

  assign tag     = bus.PrAddr[31:4];
  assign reg_idx = ctrl_reg_e'(bus.PrAddr[3:2]);

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_DEV; i++) begin
      hit[i] = (tag == BASE_TAG + 28'(i));
    end
  end

  assign ctrl_hit = (tag == CTRL_TAG);
  assign bri      = (|hit) | ctrl_hit;
  assign dev_we   = hit & {N_DEV{bus.PrWe}};
  // Only the low byte lane carries control bits; writes without it are dropped.
  assign ctrl_we  = bus.PrWe & ctrl_hit & bus.PrBE[0];

  assign ADDR  = bus.PrAddr[3:2];
  assign wdata = bus.PrWD;
  assign BE    = bus.PrBE;

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (hit[i]) rdata = dev_rdata[32*i +: 32];
    end
    if (ctrl_hit) begin
      case (reg_idx)
        REG_MASK: rdata = 32'(mask);
        REG_PEND: rdata = 32'(pend);
        REG_MODE: rdata = 32'(mode);
        default:  rdata = '0;
      endcase
    end
  end

  assign bus.PrRD = rdata;

  bridge_n_irq_ctrl #(.N_DEV(N_DEV)) u_irq_ctrl (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ctrl_we),
    .wr_idx  (reg_idx),
    .wr_data (bus.PrWD[N_DEV-1:0]),
    .dev_int (dev_int),
    .mask    (mask),
    .mode    (mode),
    .pend    (pend),
    .hw_int  (hw_int)
  );

  assign HWInt = hw_int;

endmodule
